// File: rtl/pipeline_stall_controller_if.sv
// Bundle of the hazard inputs and pipeline control outputs exchanged between
// the datapath (master) and the stall controller (slave).
interface pipeline_stall_controller_if;
  logic [3:0]  ID_OP1;
  logic [3:0]  ID_OP2;
  logic [3:0]  EX_Opcode;
  logic [3:0]  EX_FunctionCode;
  logic [3:0]  EX_DestReg;
  logic        BranchTaken;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXWrite;
  logic        IDEXBubble;
  logic        IFIDFlush;
  logic        EXMEMBubble;
  logic        MultiBusy;
  logic        MultiDone;
  logic [15:0] StallCount;

  modport master (
    output ID_OP1, ID_OP2, EX_Opcode, EX_FunctionCode, EX_DestReg, BranchTaken,
    input  PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, IFIDFlush, EXMEMBubble,
           MultiBusy, MultiDone, StallCount
  );

  modport slave (
    input  ID_OP1, ID_OP2, EX_Opcode, EX_FunctionCode, EX_DestReg, BranchTaken,
    output PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, IFIDFlush, EXMEMBubble,
           MultiBusy, MultiDone, StallCount
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for load-use, multi-cycle MUL/DIV and taken branches.
// Optional macro STALL_COUNTER_EN adds a saturating stall-cycle counter.
module pipeline_stall_controller #(
  parameter logic [3:0] LOAD_OPCODE  = 4'b1000,
  parameter logic [3:0] RTYPE_OPCODE = 4'b0001,
  parameter logic [3:0] MUL_FC       = 4'b0100,
  parameter logic [3:0] DIV_FC       = 4'b0101,
  parameter int         MUL_CYCLES   = 2,
  parameter int         DIV_CYCLES   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_stall_controller_if.slave   bus
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_CYCLES > 1) ? CNT_W'(MUL_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_CYCLES > 1) ? CNT_W'(DIV_CYCLES - 2) : '0;
  localparam logic MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic DIV_MULTI = (DIV_CYCLES > 1);

  typedef enum logic {RUN, MULDIV} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             is_mul, is_div, muldiv_ex, multi_cycle, load_use;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    is_mul      = (bus.EX_Opcode == RTYPE_OPCODE) && (bus.EX_FunctionCode == MUL_FC);
    is_div      = (bus.EX_Opcode == RTYPE_OPCODE) && (bus.EX_FunctionCode == DIV_FC);
    muldiv_ex   = is_mul || is_div;
    multi_cycle = is_mul ? MUL_MULTI : DIV_MULTI;
    load_val    = is_mul ? MUL_LOAD : DIV_LOAD;
    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    load_use    = (bus.EX_Opcode == LOAD_OPCODE) && (bus.EX_DestReg != 4'd0) &&
                  ((bus.EX_DestReg == bus.ID_OP1) || (bus.EX_DestReg == bus.ID_OP2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (!bus.BranchTaken && muldiv_ex && multi_cycle) begin
          state_d = MULDIV;
          cnt_d   = load_val;
        end
      end
      MULDIV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b1;
    bus.IFIDWrite   = 1'b1;
    bus.IDEXWrite   = 1'b1;
    bus.IDEXBubble  = 1'b0;
    bus.IFIDFlush   = 1'b0;
    bus.EXMEMBubble = 1'b0;
    bus.MultiBusy   = 1'b0;
    bus.MultiDone   = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (bus.BranchTaken) begin
            bus.IFIDFlush  = 1'b1;
            bus.IDEXBubble = 1'b1;
          end else if (muldiv_ex && multi_cycle) begin
            bus.PCWrite     = 1'b0;
            bus.IFIDWrite   = 1'b0;
            bus.IDEXWrite   = 1'b0;
            bus.EXMEMBubble = 1'b1;
          end else if (muldiv_ex) begin
            bus.MultiDone = 1'b1;
          end else if (load_use) begin
            bus.PCWrite    = 1'b0;
            bus.IFIDWrite  = 1'b0;
            bus.IDEXBubble = 1'b1;
          end
        end
        MULDIV: begin
          bus.MultiBusy = 1'b1;
          if (cnt_q != '0) begin
            bus.PCWrite     = 1'b0;
            bus.IFIDWrite   = 1'b0;
            bus.IDEXWrite   = 1'b0;
            bus.EXMEMBubble = 1'b1;
          end else begin
            bus.MultiDone = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!bus.PCWrite && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.StallCount = stall_cnt_q;
`else
  assign bus.StallCount = 16'h0000;
`endif

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Sequences the 5-stage pipeline around hazards that operand forwarding cannot resolve.
  - Load-use: a one-cycle bubble.
  - Multi-cycle MUL/DIV occupying EX: a counted hold.
  - Taken branch: IF/ID flush.
- Sits beside the forwarding logic. Drives pipeline-register write enables, bubble/flush controls and the PC write enable.

Parameters:
- LOAD_OPCODE, 4'b1000, opcode of load word.
- RTYPE_OPCODE, 4'b0001, opcode of register-register ALU ops.
- MUL_FC, 4'b0100, function code of multiply.
- DIV_FC, 4'b0101, function code of divide.
- MUL_CYCLES, 2, total EX occupancy of multiply (≥1).
- DIV_CYCLES, 4, total EX occupancy of divide (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ID_OP1  in  4  source register 1 of instruction in ID
- ID_OP2  in  4  source register 2 of instruction in ID
- EX_Opcode  in  4  opcode of instruction in EX (4'b0000 = bubble/NOP)
- EX_FunctionCode  in  4  function code of instruction in EX
- EX_DestReg  in  4  destination register of instruction in EX
- BranchTaken  in  1  branch resolved taken in EX this cycle
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register write enable
- IDEXWrite  out  1  ID/EX register write enable
- IDEXBubble  out  1  load NOP into ID/EX
- IFIDFlush  out  1  clear IF/ID
- EXMEMBubble  out  1  load NOP into EX/MEM
- MultiBusy  out  1  high while in MULDIV
- MultiDone  out  1  one-cycle pulse on final MUL/DIV cycle
- StallCount  out  16  stall-cycle counter (see Optional Feature)

Behaviour:
- FSM states RUN, MULDIV. Down-counter cnt, 3 bits wide, sized for max(MUL_CYCLES, DIV_CYCLES)−2.
- Reset (synchronous, wins over everything, including mid-MULDIV):
  - state=RUN, cnt=0, StallCount=0.
  - Outputs during the reset cycle are the RUN defaults.
- RUN defaults: PCWrite=IFIDWrite=IDEXWrite=1; IDEXBubble=IFIDFlush=EXMEMBubble=MultiBusy=MultiDone=0.
- Outputs are Mealy (combinational from state and inputs). State and cnt are registered.
- muldiv_ex = (EX_Opcode==RTYPE_OPCODE) && (EX_FunctionCode==MUL_FC || DIV_FC). N = MUL_CYCLES or DIV_CYCLES accordingly.
- RUN priority, highest first:
  1. BranchTaken: IFIDFlush=1, IDEXBubble=1. Load-use is ignored.
  2. muldiv_ex && N>1: PCWrite=IFIDWrite=IDEXWrite=0, EXMEMBubble=1, MultiBusy=0. Next state MULDIV, cnt<=N−2.
  3. muldiv_ex && N==1: no stall, MultiDone=1.
  4. Load-use, i.e. EX_Opcode==LOAD_OPCODE && EX_DestReg!=0 && (EX_DestReg==ID_OP1 || EX_DestReg==ID_OP2): PCWrite=IFIDWrite=0, IDEXBubble=1 for exactly this cycle. The bubble removes the hazard next cycle.
- MULDIV:
  - MultiBusy=1.
  - cnt!=0: stall outputs as in RUN item 2; cnt decrements.
  - cnt==0: all writes enabled, EXMEMBubble=0, MultiDone=1. The MUL/DIV advances to MEM. Next state RUN.
  - BranchTaken and load-use are ignored in MULDIV; they cannot legally coincide.
- Total stall cycles per MUL/DIV = N−1. Back-to-back MUL/DIV: the second enters EX the cycle after MultiDone and restarts from RUN item 2.
- Register 0 never raises load-use.

Optional Feature:
- Macro STALL_COUNTER_EN.
- Defined: StallCount increments by 1 on every cycle with PCWrite==0; saturates at 16'hFFFF; cleared by reset.
- Undefined: StallCount is tied to 16'h0000 and no counter flops exist.

Test Plan:
- Load R3 in EX, ID_OP2=3 → one cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle EX_Opcode=0 → all defaults.
- MUL in EX (MUL_CYCLES=2) → 1 stall cycle, then MultiDone=1, MultiBusy=1 on that cycle only; StallCount=1 with STALL_COUNTER_EN.
- DIV in EX (DIV_CYCLES=4) → EXMEMBubble high 3 cycles, MultiDone on 4th; then DIV again → another 3-cycle stall.
- BranchTaken=1 while load-use also true → IFIDFlush=1, IDEXBubble=1, PCWrite=1.
- Reset asserted in 2nd cycle of a DIV hold → next cycle state RUN, MultiBusy=0, StallCount=0.
- Load with EX_DestReg=0, ID_OP1=0 → no stall.
